// File: rtl/nv_nvdla_cacc_csb_reg_master_pkg.sv
// Shared constants for the CACC CSB request master.
// Gives the field positions of the CSB request and response words, their widths,
// and the default CACC word-address window.
package nv_nvdla_cacc_csb_reg_master_pkg;

  localparam int REQ_PD_W  = 63;
  localparam int RESP_PD_W = 34;

  // Request field positions
  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_ADDR_MSB    = 21;
  localparam int REQ_WDAT_LSB    = 22;
  localparam int REQ_WDAT_MSB    = 53;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int REQ_IGN_LSB     = 56;  // srcpriv, wrbe, level: not used by this block
  localparam int REQ_IGN_MSB     = 62;

  // Response bit positions
  localparam int RESP_ERR_BIT = 32;
  localparam int RESP_WR_BIT  = 33;

  // Value required on word-address bits [21:10] for a request to reach CACC
  localparam logic [11:0] CACC_BASE_ADDR_HI = 12'h009;

  // Request fields held in the stage-1 register
  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        nposted;
  } s1_req_t;

  // True when a word address falls inside the window selected by base_hi
  function automatic logic addr_in_range(input logic [21:0] addr, input logic [11:0] base_hi);
    return (addr[21:10] == base_hi);
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_csb_reg_master.sv
// CSB request master for the CACC register file: CSB request -> register-slave port -> CSB response.
// Ports: nvdla_core_clk/rstn; csb2cacc_req_* (request in); cacc2csb_resp_* (response out);
//        reg_offset/reg_wr_en/reg_wr_data (slave drive); reg_rd_data (combinational slave read data).
// Latency 2 cycles, one request per cycle; no back-pressure, so ready depends only on reset.
module nv_nvdla_cacc_csb_reg_master
  import nv_nvdla_cacc_csb_reg_master_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR_HI = CACC_BASE_ADDR_HI
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  csb2cacc_req_pvld,
  output logic                  csb2cacc_req_prdy,
  input  logic [REQ_PD_W-1:0]   csb2cacc_req_pd,
  output logic                  cacc2csb_resp_valid,
  output logic [RESP_PD_W-1:0]  cacc2csb_resp_pd,
  output logic [11:0]           reg_offset,
  output logic                  reg_wr_en,
  output logic [31:0]           reg_wr_data,
  input  logic [31:0]           reg_rd_data
);

  s1_req_t s1_req;
  s1_req_t req_in;
  logic    s1_vld;
  logic    s1_in_range;
  logic    accept;
  logic    unused_req_bits;

  // srcpriv, wrbe and level carry no meaning here: every write is a full word
  assign unused_req_bits = ^csb2cacc_req_pd[REQ_IGN_MSB:REQ_IGN_LSB];

  assign req_in.addr    = csb2cacc_req_pd[REQ_ADDR_MSB:REQ_ADDR_LSB];
  assign req_in.wdat    = csb2cacc_req_pd[REQ_WDAT_MSB:REQ_WDAT_LSB];
  assign req_in.write   = csb2cacc_req_pd[REQ_WRITE_BIT];
  assign req_in.nposted = csb2cacc_req_pd[REQ_NPOSTED_BIT];

  // The pipeline never stalls, so the only time a request cannot be taken is in reset
  assign csb2cacc_req_prdy = nvdla_core_rstn;
  assign accept            = csb2cacc_req_pvld & csb2cacc_req_prdy;

  // Stage 1: request register. The payload only loads on accept so the slave-side
  // offset and data hold their last value while idle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld <= 1'b0;
      s1_req <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_req <= req_in;
      end
    end
  end

  assign s1_in_range = addr_in_range(s1_req.addr, BASE_ADDR_HI);
  assign reg_offset  = {s1_req.addr[9:0], 2'b00};
  assign reg_wr_data = s1_req.wdat;
  assign reg_wr_en   = s1_vld & s1_req.write & s1_in_range;

  // Stage 2: response register. The slave read data is sampled in the same cycle the
  // offset is presented; out-of-range reads return zero with the error bit set.
  // Posted writes pass through the stage but never raise valid.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cacc2csb_resp_valid <= 1'b0;
      cacc2csb_resp_pd    <= '0;
    end else begin
      cacc2csb_resp_valid <= s1_vld & (~s1_req.write | s1_req.nposted);
      if (s1_vld) begin
        cacc2csb_resp_pd[RESP_WR_BIT]  <= s1_req.write;
        cacc2csb_resp_pd[RESP_ERR_BIT] <= ~s1_in_range;
        cacc2csb_resp_pd[31:0]         <= (~s1_req.write & s1_in_range) ? reg_rd_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cacc_csb_reg_master.sv
// Self-checking bench for nv_nvdla_cacc_csb_reg_master.
// A small register slave (read-only status word at offset 0, 7 writable words) hangs off the slave port.
// Directed table, hand sequences for back-to-back and mid-flight reset, then random traffic vs a model.
module tb_nv_nvdla_cacc_csb_reg_master;

  localparam logic [31:0] STATUS_VAL = 32'h0001_0002;  // status_1=2'b01 at [17:16], status_0=2'b10 at [1:0]

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        pvld = 1'b0;
  logic        prdy;
  logic [62:0] req_pd = '0;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic [11:0] reg_offset;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_cacc_csb_reg_master dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .csb2cacc_req_pvld  (pvld),
    .csb2cacc_req_prdy  (prdy),
    .csb2cacc_req_pd    (req_pd),
    .cacc2csb_resp_valid(resp_valid),
    .cacc2csb_resp_pd   (resp_pd),
    .reg_offset         (reg_offset),
    .reg_wr_en          (reg_wr_en),
    .reg_wr_data        (reg_wr_data),
    .reg_rd_data        (reg_rd_data)
  );

  // ---------------- register slave ----------------
  logic [31:0] slave_mem [0:7];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) slave_mem[i] <= 32'h0;
    end else if (reg_wr_en && reg_offset[11:2] != 10'd0) begin
      slave_mem[reg_offset[4:2]] <= reg_wr_data;
    end
  end
  assign reg_rd_data = (reg_offset[11:2] == 10'd0) ? STATUS_VAL : slave_mem[reg_offset[4:2]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Ignored request fields are randomised to show they have no effect
  function automatic logic [62:0] mk_pd(input logic [21:0] a, input logic [31:0] d,
                                        input logic w, input logic np);
    logic [6:0] ign;
    ign = 7'($urandom);
    return {ign, np, w, d, a};
  endfunction

  // ---------------- reference model ----------------
  // Requests are executed in order against an abstract register array at accept time;
  // each accepted request yields an expectation for the cycle after accept (slave drive)
  // and the cycle after that (response).
  typedef struct {
    int          s1_cyc;
    logic [11:0] off;
    logic        wr;
    logic [31:0] wdat;
    logic        rv;
    logic [33:0] pd;
  } exp_t;

  exp_t        pend[$];
  int          cyc = 0;
  logic [31:0] ref_mem [0:7];
  exp_t        m_e;
  logic [21:0] m_a;
  logic [31:0] m_d, m_rd;
  logic        m_w, m_np, m_inr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend.delete();
      for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    end else begin
      cyc++;
      while (pend.size() > 0 && pend[0].s1_cyc + 1 < cyc) void'(pend.pop_front());
      if (pvld) begin
        m_a   = req_pd[21:0];
        m_d   = req_pd[53:22];
        m_w   = req_pd[54];
        m_np  = req_pd[55];
        m_inr = (m_a[21:10] == 12'h009);
        m_rd  = 32'h0;
        if (m_inr && !m_w) m_rd = (m_a[9:0] == 10'd0) ? STATUS_VAL : ref_mem[m_a[2:0]];
        if (m_inr && m_w && m_a[9:0] != 10'd0) ref_mem[m_a[2:0]] = m_d;
        m_e.s1_cyc = cyc;
        m_e.off    = {m_a[9:0], 2'b00};
        m_e.wr     = m_w && m_inr;
        m_e.wdat   = m_d;
        m_e.rv     = !m_w || m_np;
        m_e.pd     = {m_w, !m_inr, m_rd};
        pend.push_back(m_e);
      end
    end
  end

  logic        c_wr, c_s1, c_rv;
  logic [11:0] c_off;
  logic [31:0] c_dat;
  logic [33:0] c_pd;

  always @(negedge clk) begin
    c_wr = 1'b0; c_s1 = 1'b0; c_rv = 1'b0;
    c_off = '0; c_dat = '0; c_pd = '0;
    foreach (pend[i]) begin
      if (pend[i].s1_cyc == cyc) begin
        c_s1 = 1'b1; c_wr = pend[i].wr; c_off = pend[i].off; c_dat = pend[i].wdat;
      end
      if (pend[i].s1_cyc + 1 == cyc) begin
        c_rv = pend[i].rv; c_pd = pend[i].pd;
      end
    end
    check("mon_prdy", 64'(prdy), 64'(rstn));
    check("mon_wr_en", 64'(reg_wr_en), 64'(c_wr));
    if (c_s1) check("mon_offset", 64'(reg_offset), 64'(c_off));
    if (c_wr) check("mon_wr_data", 64'(reg_wr_data), 64'(c_dat));
    check("mon_resp_valid", 64'(resp_valid), 64'(c_rv));
    if (c_rv) check("mon_resp_pd", 64'(resp_pd), 64'(c_pd));
  end

  // ---------------- directed stimulus ----------------
  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        nposted;
    logic        exp_wr_en;
    logic        exp_rv;
    logic [33:0] exp_pd;
  } vec_t;

  vec_t vecs [0:8];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prdy"},    64'(prdy),        64'h0);
    check({tag, "_offset"},  64'(reg_offset),  64'h0);
    check({tag, "_wr_en"},   64'(reg_wr_en),   64'h0);
    check({tag, "_wr_data"}, 64'(reg_wr_data), 64'h0);
    check({tag, "_rv"},      64'(resp_valid),  64'h0);
    check({tag, "_pd"},      64'(resp_pd),     64'h0);
  endtask

  initial begin
    //          addr      wdat           wr    np    wr_en rv    pd
    vecs[0] = '{22'h2400, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 34'h0_0001_0002}; // status read
    vecs[1] = '{22'h2401, 32'h1,         1'b1, 1'b1, 1'b1, 1'b1, 34'h2_0000_0000}; // np write producer=1
    vecs[2] = '{22'h2401, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 34'h0_0000_0001}; // read back
    vecs[3] = '{22'h2401, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 34'h0};           // posted write producer=0
    vecs[4] = '{22'h2401, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 34'h0_0000_0000}; // read back 0
    vecs[5] = '{22'h0400, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 34'h1_0000_0000}; // out-of-range read
    vecs[6] = '{22'h0401, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 34'h3_0000_0000}; // out-of-range np write
    vecs[7] = '{22'h3401, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0};           // out-of-range posted
    vecs[8] = '{22'h2401, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 34'h0_0000_0000}; // untouched by above

    #1 rstn = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pvld   = 1'b1;
      req_pd = mk_pd(vecs[i].addr, vecs[i].wdat, vecs[i].write, vecs[i].nposted);
      @(posedge clk); #1;
      pvld = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_wr_en", i), 64'(reg_wr_en), 64'(vecs[i].exp_wr_en));
      check($sformatf("tbl%0d_offset", i), 64'(reg_offset), 64'({vecs[i].addr[9:0], 2'b00}));
      if (vecs[i].exp_wr_en) check($sformatf("tbl%0d_wr_data", i), 64'(reg_wr_data), 64'(vecs[i].wdat));
      @(negedge clk);
      check($sformatf("tbl%0d_rv", i), 64'(resp_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) check($sformatf("tbl%0d_pd", i), 64'(resp_pd), 64'(vecs[i].exp_pd));
    end

    // Back-to-back write then read of the same register
    @(posedge clk); #1;
    pvld = 1'b1; req_pd = mk_pd(22'h2401, 32'h1, 1'b1, 1'b1);
    @(posedge clk); #1;
    req_pd = mk_pd(22'h2401, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pvld = 1'b0;
    @(negedge clk);
    check("b2b_wr_rv", 64'(resp_valid), 64'h1);
    check("b2b_wr_pd", 64'(resp_pd), 64'h2_0000_0000);
    @(negedge clk);
    check("b2b_rd_rv", 64'(resp_valid), 64'h1);
    check("b2b_rd_pd", 64'(resp_pd), 64'h0_0000_0001);

    // Reset the cycle after a read is accepted: no response may escape
    @(posedge clk); #1;
    pvld = 1'b1; req_pd = mk_pd(22'h2400, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pvld = 1'b0; rstn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk); check("midrst_rv_a", 64'(resp_valid), 64'h0);
    @(negedge clk); check("midrst_rv_b", 64'(resp_valid), 64'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    pvld = 1'b1; req_pd = mk_pd(22'h2400, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pvld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_rv", 64'(resp_valid), 64'h1);
    check("post_rst_pd", 64'(resp_pd), 64'h0_0001_0002);

    // Random traffic, checked by the model
    for (int n = 0; n < 400; n++) begin
      logic [11:0] hi;
      @(posedge clk); #1;
      pvld = ($urandom_range(0, 3) != 0);
      hi   = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 8)) : 12'h009;
      req_pd = mk_pd({hi, 7'h0, 3'($urandom_range(0, 7))}, $urandom,
                     1'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    pvld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cacc_csb_reg_master.md
# nv_nvdla_cacc_csb_reg_master

CSB-side request master for the CACC register file: accepts CSB requests from the configuration bus, drives the register-slave port (offset/write-enable/write-data) of the CACC register block, samples its read data, and returns read and non-posted-write responses to CSB. It sits between the csb2cacc port and the CACC single/dual register blocks. Fully pipelined, one request per cycle, fixed latency.

## Interface
- BASE_ADDR_HI, 12'h009, value required on request address bits [21:10] (CACC word-address window); any other value is an out-of-range request.
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset; one clock, asynchronous, active-low.
- csb2cacc_req_pvld  in  1  request valid.
- csb2cacc_req_prdy  out  1  request ready.
- csb2cacc_req_pd  in  63  request: [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv, [60:57] wrbe, [62:61] level.
- cacc2csb_resp_valid  out  1  response valid, single-cycle pulse, no back-pressure.
- cacc2csb_resp_pd  out  34  response: [31:0] rdat, [32] error, [33] is_write.
- reg_offset  out  12  byte offset to register slave.
- reg_wr_en  out  1  register write strobe.
- reg_wr_data  out  32  register write data.
- reg_rd_data  in  32  combinational read data from register slave for reg_offset.

## Operation
- csb2cacc_req_prdy is 0 while nvdla_core_rstn is low and 1 otherwise; a request is accepted on any cycle with pvld=1.
- Stage 1 (request register): on accept, capture addr, wdat, write, nposted; set s1_vld. No accept: s1_vld clears.
- Stage 1 drive: reg_offset = {addr[9:0], 2'b00}; reg_wr_data = wdat; reg_wr_en = s1_vld & write & in_range, where in_range = (addr[21:10] == BASE_ADDR_HI).
- reg_offset and reg_wr_data hold their last value when s1_vld=0; reg_wr_en is 0.
- srcpriv, wrbe and level are ignored; every write is a full 32-bit write.
- Stage 2 (response register): when s1_vld, capture rdat = (read & in_range) ? reg_rd_data : 32'h0; error = !in_range; is_write = write.
- cacc2csb_resp_valid asserts when stage 2 holds a read, or a write with nposted=1. Posted writes (nposted=0) produce no response.
- Out-of-range requests: no reg_wr_en; read returns rdat=0, error=1; non-posted write returns error=1; posted write is dropped silently.
- Responses are returned strictly in request order.

## Timing
- Reset values: csb2cacc_req_prdy=0, reg_offset=12'h0, reg_wr_en=0, reg_wr_data=32'h0, cacc2csb_resp_valid=0, cacc2csb_resp_pd=34'h0; internal s1_vld=0.
- Request accepted at edge T → reg_wr_en/reg_offset valid during cycle T+1 → slave flop updates at edge T+2; reg_rd_data sampled at edge T+2 → resp_valid high during cycle T+2 (2-cycle accept-to-response latency).
- Back-to-back: full throughput, one request per cycle, one response per cycle.
- Read immediately after write to the same offset (accepted at T and T+1) returns the new value; the write commits at edge T+2 and the read samples at edge T+3.
- Reset asserted mid-operation: stage 1 and stage 2 clear asynchronously; in-flight requests are discarded with no response and no write strobe. The first accept is possible on the first edge after reset deassertion.

## Structure
- Shared package (cacc CSB package): request field LSB/MSB constants, response bit positions (RESP_ERR_BIT=32, RESP_WR_BIT=33), CACC_BASE_ADDR_HI default, request/response widths.
- No sub-module; two pipeline stages in a single module, 120–200 lines.

## Test plan
- Read 0x9000 (addr=22'h2400, write=0), slave status_0=2'b10, status_1=2'b01 → resp_valid 2 cycles after accept, pd = {1'b0, 1'b0, 32'h0001_0002}.
- Non-posted write addr 22'h2401, wdat=1 → reg_offset=12'h004, reg_wr_en pulse with data 1, producer=1; response pd = {1,0,32'h0}.
- Posted write of the same → producer updates; resp_valid stays 0 throughout.
- Out-of-range read addr 22'h0400 and non-posted write → no reg_wr_en; responses carry error=1 and rdat=0.
- Back-to-back write producer=1, then read 0x9004 on the next cycle → read response rdat[0]=1; one response per cycle with no gaps.
- Assert nvdla_core_rstn low the cycle after accepting a read → no response, all outputs return to reset values, prdy=0 until release.
